// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming(7,4)+parity code layout and decode status for encoder and receiver
package hamming_pkg;
    localparam int P1 = 0;
    localparam int P2 = 1;
    localparam int D0 = 2;
    localparam int P3 = 3;
    localparam int D1 = 4;
    localparam int D2 = 5;
    localparam int D3 = 6;
    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    typedef enum logic [1:0] {CLEAN = 2'd0, CORR = 2'd1, DERR = 2'd2} status_t;
    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        return {c[D3], c[D2], c[D1], c[D0]};
    endfunction
endpackage

// File: rtl/hamming_secded_rx_if.sv
// hamming_secded_rx_if: input/output valid-ready buses of the SECDED receiver
interface hamming_secded_rx_if;
    import hamming_pkg::*;
    logic              ip_valid;
    logic              op_in_ready;
    logic [CODE_W-1:0] ip_hamm_code;
    logic              ip_parity;
    logic              op_valid;
    logic              ip_out_ready;
    logic [DATA_W-1:0] op_data;
    logic [2:0]        op_syndrome;
    logic              op_corrected;
    logic              op_uncorrectable;
    modport master (output ip_valid, ip_hamm_code, ip_parity, ip_out_ready,
                    input op_in_ready, op_valid, op_data, op_syndrome, op_corrected, op_uncorrectable);
    modport slave (input ip_valid, ip_hamm_code, ip_parity, ip_out_ready,
                   output op_in_ready, op_valid, op_data, op_syndrome, op_corrected, op_uncorrectable);
endinterface

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: syndrome {s3,s2,s1} and overall parity check q of a received word
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic              parity,
    output logic [2:0]        syndrome,
    output logic              q
);
    assign syndrome = {code[3] ^ code[4] ^ code[5] ^ code[6],
                       code[1] ^ code[2] ^ code[5] ^ code[6],
                       code[0] ^ code[2] ^ code[4] ^ code[6]};
    assign q = ^{parity, code};
endmodule

// File: rtl/hamming_secded_rx.sv
// hamming_secded_rx: 2-stage SECDED Hamming(7,4) decoder with valid/ready flow control
// Saturating error counters are built only when HAMM_ERR_CNT_EN is defined.
module hamming_secded_rx
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             ip_clk,
    input  logic             ip_rst,
    hamming_secded_rx_if.slave bus,
    input  logic             ip_cnt_clr,
    output logic [CNT_W-1:0] op_cnt_single,
    output logic [CNT_W-1:0] op_cnt_double
);
    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [2:0]        s1_syn;
    logic              s1_q;
    logic [2:0]        syn;
    logic              q;
    logic              s1_en;
    logic              s2_en;
    status_t           status;
    logic [CODE_W-1:0] flip;
    hamming_syndrome u_syn (.code(bus.ip_hamm_code), .parity(bus.ip_parity), .syndrome(syn), .q(q));
    assign s2_en = !bus.op_valid | bus.ip_out_ready;
    assign s1_en = !s1_valid | s2_en;
    assign bus.op_in_ready = s1_en;
    // q=1 means an odd number of flips: correct the code bit named by the syndrome, if any
    always_comb begin
        status = (s1_syn == 3'd0 && !s1_q) ? CLEAN : s1_q ? CORR : DERR;
        flip = (s1_q && s1_syn != 3'd0) ? CODE_W'(1) << (s1_syn - 3'd1) : '0;
    end
    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
            s1_valid <= 1'b0;
            s1_code <= '0;
            s1_syn <= '0;
            s1_q <= 1'b0;
            bus.op_valid <= 1'b0;
            bus.op_data <= '0;
            bus.op_syndrome <= '0;
            bus.op_corrected <= 1'b0;
            bus.op_uncorrectable <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= bus.ip_valid;
                if (bus.ip_valid) begin
                    s1_code <= bus.ip_hamm_code;
                    s1_syn <= syn;
                    s1_q <= q;
                end
            end
            if (s2_en) begin
                bus.op_valid <= s1_valid;
                if (s1_valid) begin
                    bus.op_data <= extract(s1_code ^ flip);
                    bus.op_syndrome <= s1_syn;
                    bus.op_corrected <= status == CORR;
                    bus.op_uncorrectable <= status == DERR;
                end
            end
        end
    end
`ifdef HAMM_ERR_CNT_EN
    logic xfer;
    assign xfer = bus.op_valid & bus.ip_out_ready;
    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
            op_cnt_single <= '0;
            op_cnt_double <= '0;
        end else if (ip_cnt_clr) begin
            op_cnt_single <= '0;
            op_cnt_double <= '0;
        end else if (xfer) begin
            if (bus.op_corrected && !(&op_cnt_single)) op_cnt_single <= op_cnt_single + CNT_W'(1);
            if (bus.op_uncorrectable && !(&op_cnt_double)) op_cnt_double <= op_cnt_double + CNT_W'(1);
        end
    end
`else
    logic cnt_clr_unused;
    assign cnt_clr_unused = ip_cnt_clr;
    assign op_cnt_single = '0;
    assign op_cnt_double = '0;
`endif
endmodule

// File: tb/tb_hamming_secded_rx.sv
// tb_hamming_secded_rx: directed vector table plus stall, reset and counter sequences for hamming_secded_rx
module tb_hamming_secded_rx;
    import hamming_pkg::*;
    localparam int CW = 3;
    localparam int SAT = 7;
`ifdef HAMM_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cnt_clr = 1'b0;
    logic [CW-1:0] cnt_s;
    logic [CW-1:0] cnt_d;
    int n_chk = 0;
    int n_pass = 0;
    int exp_s = 0;
    int exp_d = 0;
    always #5 clk = ~clk;
    hamming_secded_rx_if bus();
    hamming_secded_rx #(.CNT_W(CW)) dut (
        .ip_clk(clk), .ip_rst(rst), .bus(bus), .ip_cnt_clr(cnt_clr),
        .op_cnt_single(cnt_s), .op_cnt_double(cnt_d)
    );
    typedef struct {
        logic [6:0] code;
        logic       par;
        logic [3:0] data;
        logic [2:0] syn;
        logic       corr;
        logic       unc;
    } vec_t;
    vec_t v[10];
    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction
    function automatic int sat(input int x);
        return CNT_ON ? (x > SAT ? SAT : x) : 0;
    endfunction
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask
    task automatic push_word(input logic [6:0] c, input logic p);
        @(negedge clk);
        bus.ip_valid = 1'b1;
        bus.ip_hamm_code = c;
        bus.ip_parity = p;
        @(negedge clk);
        bus.ip_valid = 1'b0;
    endtask
    initial begin
        logic [3:0] exp_q[$];
        logic [3:0] prev_data;
        logic prev_stall;
        int occ;
        int idx;
        int rcv;
        v[0] = '{7'b1010101, 1'b0, 4'b1011, 3'd0, 1'b0, 1'b0};
        v[1] = '{7'b1000101, 1'b0, 4'b1011, 3'd5, 1'b1, 1'b0};
        v[2] = '{7'b0110011, 1'b1, 4'b0110, 3'd0, 1'b1, 1'b0};
        v[3] = '{7'b0010100, 1'b0, 4'b0011, 3'd6, 1'b0, 1'b1};
        v[4] = '{7'b0000000, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0};
        v[5] = '{7'b1111111, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0};
        v[6] = '{7'b1111110, 1'b1, 4'b1111, 3'd1, 1'b1, 1'b0};
        v[7] = '{7'b1000000, 1'b0, 4'b0000, 3'd7, 1'b1, 1'b0};
        v[8] = '{7'b0000110, 1'b0, 4'b0001, 3'd1, 1'b0, 1'b1};
        v[9] = '{7'b1111111, 1'b0, 4'b1111, 3'd0, 1'b1, 1'b0};
        bus.ip_valid = 1'b0;
        bus.ip_hamm_code = '0;
        bus.ip_parity = 1'b0;
        bus.ip_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.op_valid, 0);
        chk("rst_data", bus.op_data, 0);
        chk("rst_syn", bus.op_syndrome, 0);
        chk("rst_flags", {bus.op_corrected, bus.op_uncorrectable}, 0);
        chk("rst_cnt", {cnt_s, cnt_d}, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push_word(v[i].code, v[i].par);
            chk($sformatf("v%0d_latency", i), bus.op_valid, 0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), bus.op_valid, 1);
            chk($sformatf("v%0d_data", i), bus.op_data, v[i].data);
            chk($sformatf("v%0d_syn", i), bus.op_syndrome, v[i].syn);
            chk($sformatf("v%0d_corr", i), bus.op_corrected, v[i].corr);
            chk($sformatf("v%0d_unc", i), bus.op_uncorrectable, v[i].unc);
            exp_s += v[i].corr;
            exp_d += v[i].unc;
            @(negedge clk);
            chk($sformatf("v%0d_drained", i), bus.op_valid, 0);
            chk($sformatf("v%0d_cnt_single", i), cnt_s, sat(exp_s));
            chk($sformatf("v%0d_cnt_double", i), cnt_d, sat(exp_d));
        end
        occ = 0;
        idx = 0;
        rcv = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int cyc = 0; cyc < 100 && rcv < 8; cyc++) begin
            @(negedge clk);
            bus.ip_out_ready = (cyc % 2) == 0;
            bus.ip_valid = idx < 8;
            bus.ip_hamm_code = enc(4'(idx * 5 + 3));
            bus.ip_parity = ^enc(4'(idx * 5 + 3));
            #1;
            if (prev_stall) begin
                chk("bp_hold_valid", bus.op_valid, 1);
                chk("bp_hold_data", bus.op_data, prev_data);
            end
            chk("bp_in_ready", bus.op_in_ready, (occ == 2 && !bus.ip_out_ready) ? 0 : 1);
            if (bus.op_valid && bus.ip_out_ready) begin
                if (exp_q.size() > 0) begin
                    chk("bp_data", bus.op_data, exp_q.pop_front());
                    chk("bp_flags", {bus.op_corrected, bus.op_uncorrectable}, 0);
                end else chk("bp_spurious", 1, 0);
                rcv++;
                occ--;
            end
            if (bus.ip_valid && bus.op_in_ready) begin
                exp_q.push_back(4'(idx * 5 + 3));
                idx++;
                occ++;
            end
            prev_stall = bus.op_valid && !bus.ip_out_ready;
            prev_data = bus.op_data;
        end
        chk("bp_received", rcv, 8);
        @(negedge clk);
        bus.ip_valid = 1'b0;
        bus.ip_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_no_dup", bus.op_valid, 0);
        chk("bp_cnt_single", cnt_s, sat(exp_s));
        bus.ip_out_ready = 1'b0;
        bus.ip_valid = 1'b1;
        bus.ip_hamm_code = enc(4'd5);
        bus.ip_parity = ^enc(4'd5);
        @(negedge clk);
        bus.ip_hamm_code = enc(4'd9);
        bus.ip_parity = ^enc(4'd9);
        @(negedge clk);
        bus.ip_valid = 1'b0;
        chk("full_valid", bus.op_valid, 1);
        chk("full_in_ready", bus.op_in_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", bus.op_valid, 0);
        chk("async_rst_data", bus.op_data, 0);
        chk("async_rst_cnt", {cnt_s, cnt_d}, 0);
        exp_s = 0;
        exp_d = 0;
        @(negedge clk);
        rst = 1'b0;
        bus.ip_out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_dropped", bus.op_valid, 0);
        end
        for (int i = 0; i < 9; i++) begin
            push_word(v[1].code, v[1].par);
            repeat (2) @(negedge clk);
            exp_s++;
            chk($sformatf("sat_single_%0d", i), cnt_s, sat(exp_s));
        end
        push_word(v[3].code, v[3].par);
        repeat (2) @(negedge clk);
        exp_d++;
        chk("cnt_double_pre_clr", cnt_d, sat(exp_d));
        push_word(v[1].code, v[1].par);
        chk("clr_word_pending", bus.op_valid, 0);
        @(negedge clk);
        chk("clr_word_valid", bus.op_valid, 1);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_wins_single", cnt_s, 0);
        chk("clr_wins_double", cnt_d, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
